// File: rtl/lsu_wb_sender_if.sv
// lsu_wb_sender_if: LSU <-> memory request/response bus.
// Master drives requests, slave answers with gnt/rvalid.
interface lsu_wb_sender_if #(
  parameter int AW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_wmask,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_wmask,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_wb_sender.sv
// lsu_wb_sender: LSU back end, one access per instruction.
// Latches the EXU op, runs the bus, holds result for WBU.
module lsu_wb_sender #(
  parameter int AW = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EXU_valid,
  output logic        LSU_ready,
  input  logic [31:0] res,
  input  logic [31:0] wdata,
  input  logic        memr,
  input  logic        memw,
  input  logic [2:0]  funct3,
  input  logic        memtoreg,
  input  logic        regw,
  lsu_wb_sender_if.master mem,
  output logic        LSU_valid,
  input  logic        WBU_ready,
  output logic [31:0] dataout,
  output logic [31:0] res_o,
  output logic        memtoreg_o,
  output logic        regw_o,
  output logic        lsu_err
);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   res_q, dout_q, wdat_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    wmask_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          we_q, ld_q;
  logic          mt_q, regw_q, err_q;

  logic          accept;
  logic [1:0]    off;
  logic          acc, is_st, mis, bad_f3;
  logic [3:0]    mask;
  logic [31:0]   w, ld_fmt;

  assign accept = EXU_valid & LSU_ready;
  assign off    = res[1:0];
  assign acc    = memr | memw;
  assign is_st  = memw & ~memr;

  // Access decode on the incoming op.
  always_comb begin
    mis    = 1'b0;
    bad_f3 = 1'b0;
    mask   = 4'b1111;
    unique case (1'b1)
      (funct3[1:0] == 2'b00): begin
        mask = 4'b0001 << off;
      end
      (funct3[1:0] == 2'b01): begin
        mask = 4'b0011 << off;
        mis  = acc & off[0];
      end
      default: begin
        mis  = acc & (off != 2'b00);
      end
    endcase
    if (memr) begin
      unique case (funct3)
        3'b000, 3'b001, 3'b010,
        3'b100, 3'b101: bad_f3 = 1'b0;
        default:        bad_f3 = 1'b1;
      endcase
    end
  end

  // Load lane extract and sign/zero extension.
  always_comb begin
    w = mem.mem_rdata >> {off_q, 3'b000};
    unique case (f3_q)
      3'b000:  ld_fmt = {{24{w[7]}}, w[7:0]};
      3'b001:  ld_fmt = {{16{w[15]}}, w[15:0]};
      3'b100:  ld_fmt = {24'd0, w[7:0]};
      3'b101:  ld_fmt = {16'd0, w[15:0]};
      default: ld_fmt = w;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)
              state_d = (acc & ~mis) ? REQ : DONE;
      REQ:  if (mem.mem_gnt)    state_d = WAIT;
      WAIT: if (mem.mem_rvalid) state_d = DONE;
      DONE: if (WBU_ready)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch op at accept, capture response in WAIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      res_q   <= '0;
      dout_q  <= '0;
      wdat_q  <= '0;
      addr_q  <= '0;
      wmask_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      ld_q    <= 1'b0;
      mt_q    <= 1'b0;
      regw_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      res_q   <= res;
      dout_q  <= '0;
      wdat_q  <= wdata << {off, 3'b000};
      addr_q  <= {res[AW-1:2], 2'b00};
      wmask_q <= (is_st & ~mis) ? mask : 4'b0000;
      f3_q    <= funct3;
      off_q   <= off;
      we_q    <= is_st;
      ld_q    <= memr;
      mt_q    <= memtoreg;
      regw_q  <= regw & ~mis;
      err_q   <= mis | bad_f3;
    end else if (state_q == WAIT &&
                 mem.mem_rvalid) begin
      dout_q  <= ld_q ? ld_fmt : 32'd0;
    end
  end

  assign LSU_ready     = rst & (state_q == IDLE);
  assign LSU_valid     = (state_q == DONE);
  assign mem.mem_req   = (state_q == REQ);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdat_q;
  assign mem.mem_wmask = wmask_q;
  assign dataout       = dout_q;
  assign res_o         = res_q;
  assign memtoreg_o    = mt_q;
  assign regw_o        = regw_q;
  assign lsu_err       = err_q;

endmodule

// File: tb/tb_lsu_wb_sender.sv
// tb_lsu_wb_sender: directed checks of lsu_wb_sender.
// Bench drives the memory side of the bus itself.
module tb_lsu_wb_sender;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        EXU_valid = 1'b0;
  logic        LSU_ready;
  logic [31:0] res = '0;
  logic [31:0] wdata = '0;
  logic        memr = 1'b0;
  logic        memw = 1'b0;
  logic [2:0]  funct3 = '0;
  logic        memtoreg = 1'b0;
  logic        regw = 1'b0;
  logic        LSU_valid;
  logic        WBU_ready = 1'b0;
  logic [31:0] dataout, res_o;
  logic        memtoreg_o, regw_o, lsu_err;

  int n_chk = 0;
  int n_err = 0;

  lsu_wb_sender_if #(.AW(32)) bus ();

  lsu_wb_sender #(.AW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .EXU_valid  (EXU_valid),
    .LSU_ready  (LSU_ready),
    .res        (res),
    .wdata      (wdata),
    .memr       (memr),
    .memw       (memw),
    .funct3     (funct3),
    .memtoreg   (memtoreg),
    .regw       (regw),
    .mem        (bus.master),
    .LSU_valid  (LSU_valid),
    .WBU_ready  (WBU_ready),
    .dataout    (dataout),
    .res_o      (res_o),
    .memtoreg_o (memtoreg_o),
    .regw_o     (regw_o),
    .lsu_err    (lsu_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] r,
                       input logic [31:0] wd,
                       input logic rd, input logic wr,
                       input logic [2:0] f3,
                       input logic mt, input logic rw);
    res = r; wdata = wd; memr = rd; memw = wr;
    funct3 = f3; memtoreg = mt; regw = rw;
    chk("rdy_before_issue", {31'd0, LSU_ready}, 1);
    EXU_valid = 1'b1;
    step();
    EXU_valid = 1'b0;
    memr = 1'b0; memw = 1'b0;
  endtask

  task automatic run_mem(input int gd, input int rd,
                         input logic [31:0] rdat,
                         input bit poke);
    for (int i = 0; i < gd; i++) begin
      bus.mem_rvalid = poke && (i == 0);
      step();
      bus.mem_rvalid = 1'b0;
      chk("req_held", {31'd0, bus.mem_req}, 1);
    end
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    chk("req_drop", {31'd0, bus.mem_req}, 0);
    chk("no_valid_wait", {31'd0, LSU_valid}, 0);
    for (int i = 1; i < rd; i++) begin
      step();
      chk("no_valid_wait", {31'd0, LSU_valid}, 0);
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdat;
    step();
    bus.mem_rvalid = 1'b0;
    chk("valid_after_rv", {31'd0, LSU_valid}, 1);
  endtask

  task automatic finish_wb();
    WBU_ready = 1'b1;
    step();
    WBU_ready = 1'b0;
    chk("wb_valid_low", {31'd0, LSU_valid}, 0);
    chk("wb_ready_high", {31'd0, LSU_ready}, 1);
  endtask

  task automatic load(input logic [31:0] r,
                      input logic [2:0] f3,
                      input logic [31:0] rdat,
                      input logic [31:0] exp,
                      input logic [31:0] err);
    issue(r, 32'd0, 1'b1, 1'b0, f3, 1'b1, 1'b1);
    chk("ld_req", {31'd0, bus.mem_req}, 1);
    chk("ld_we", {31'd0, bus.mem_we}, 0);
    run_mem(0, 1, rdat, 1'b0);
    chk("ld_data", dataout, exp);
    chk("ld_err", {31'd0, lsu_err}, err);
    finish_wb();
  endtask

  initial begin
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    // reset
    repeat (3) step();
    chk("rst_ready", {31'd0, LSU_ready}, 0);
    chk("rst_valid", {31'd0, LSU_valid}, 0);
    chk("rst_req", {31'd0, bus.mem_req}, 0);
    chk("rst_dout", dataout, 0);
    chk("rst_res", res_o, 0);
    chk("rst_regw", {31'd0, regw_o}, 0);
    chk("rst_err", {31'd0, lsu_err}, 0);
    chk("rst_wmask", {28'd0, bus.mem_wmask}, 0);
    rst = 1'b1;
    step();
    chk("post_rst_ready", {31'd0, LSU_ready}, 1);
    bus.mem_rvalid = 1'b1;
    step();
    bus.mem_rvalid = 1'b0;
    chk("idle_rv_valid", {31'd0, LSU_valid}, 0);
    chk("idle_rv_ready", {31'd0, LSU_ready}, 1);

    // ALU op
    issue(32'h1234, 0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
    chk("alu_valid", {31'd0, LSU_valid}, 1);
    chk("alu_res", res_o, 32'h1234);
    chk("alu_regw", {31'd0, regw_o}, 1);
    chk("alu_req", {31'd0, bus.mem_req}, 0);
    chk("alu_dout", dataout, 0);
    chk("alu_ready", {31'd0, LSU_ready}, 0);
    finish_wb();

    // lb with slow bus and backpressure
    issue(32'h8000_0003, 0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1);
    chk("lb_req", {31'd0, bus.mem_req}, 1);
    chk("lb_addr", bus.mem_addr, 32'h8000_0000);
    run_mem(2, 3, 32'h80FF_0000, 1'b0);
    chk("lb_data", dataout, 32'hFFFF_FF80);
    chk("lb_mt", {31'd0, memtoreg_o}, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", {31'd0, LSU_valid}, 1);
      chk("bp_dout", dataout, 32'hFFFF_FF80);
      chk("bp_ready", {31'd0, LSU_ready}, 0);
    end
    finish_wb();

    // lbu, with an rvalid poke during REQ
    issue(32'h8000_0003, 0, 1'b1, 1'b0, 3'b100, 1'b1, 1'b1);
    run_mem(2, 3, 32'h80FF_0000, 1'b1);
    chk("lbu_data", dataout, 32'h0000_0080);
    finish_wb();

    // sh
    issue(32'h102, 32'hABCD, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0);
    chk("sh_req", {31'd0, bus.mem_req}, 1);
    chk("sh_addr", bus.mem_addr, 32'h100);
    chk("sh_wdata", bus.mem_wdata, 32'hABCD_0000);
    chk("sh_wmask", {28'd0, bus.mem_wmask}, 32'hC);
    chk("sh_we", {31'd0, bus.mem_we}, 1);
    run_mem(0, 1, 32'hDEAD_BEEF, 1'b0);
    chk("sh_dout", dataout, 0);
    finish_wb();

    // sb lane 1
    issue(32'h41, 32'h5A, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("sb_wdata", bus.mem_wdata, 32'h0000_5A00);
    chk("sb_wmask", {28'd0, bus.mem_wmask}, 32'h2);
    run_mem(0, 1, 0, 1'b0);
    finish_wb();

    // assorted loads
    load(32'h10, 3'b010, 32'h1234_5678, 32'h1234_5678, 0);
    load(32'h2, 3'b001, 32'h89AB_0000, 32'hFFFF_89AB, 0);
    load(32'h2, 3'b101, 32'h89AB_0000, 32'h0000_89AB, 0);
    load(32'h4, 3'b011, 32'hCAFE_F00D, 32'hCAFE_F00D, 1);

    // misaligned lw
    issue(32'h2, 0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1);
    chk("mis_valid", {31'd0, LSU_valid}, 1);
    chk("mis_req", {31'd0, bus.mem_req}, 0);
    chk("mis_err", {31'd0, lsu_err}, 1);
    chk("mis_regw", {31'd0, regw_o}, 0);
    chk("mis_dout", dataout, 0);
    finish_wb();

    // reset in WAIT, late response ignored
    issue(32'h20, 0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    rst = 1'b0;
    step();
    chk("mid_rst_ready", {31'd0, LSU_ready}, 0);
    chk("mid_rst_req", {31'd0, bus.mem_req}, 0);
    rst = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_AAAA;
    step();
    bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_rv_valid", {31'd0, LSU_valid}, 0);
      chk("late_rv_ready", {31'd0, LSU_ready}, 1);
      chk("late_rv_dout", dataout, 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
